// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : uart_pkg                                                  |
// | Purpose  : Shared state encoding and elaboration helpers for uart_rx |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_IDLE = 3'd5
   } uart_rx_state_t;

   // Cycles from the detected start edge to the middle of the start bit.
   function automatic int half_div(input int divisor);
      return divisor / 2;
   endfunction

   // Mid-bit sampling needs an even divisor and room for a meaningful half period.
   function automatic bit divisor_ok(input int divisor);
      return ((divisor % 2) == 0) && (divisor >= 4);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_rx_sync                                              |
// | Purpose  : Two-flop synchronizer with selectable reset level         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module uart_rx_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage capture of an asynchronous input; resets to the line's idle level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_rx                                                   |
// | Purpose  : Oversampling UART receiver (start 0, WIDTH data, stop 1)  |
// |            with mid-bit sampling and one-cycle valid/error strobes.  |
// | Options  : UART_RX_PARITY_EN adds an even-parity bit and the         |
// |            o_parity_err output.                                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module uart_rx
   import uart_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int DIVISOR       = 100,
   parameter int LITTLE_ENDIAN = 1
) (
   input  logic             clk,
   input  logic             i_reset_n,
   input  logic             i_rx,
   output logic [WIDTH-1:0] o_data,
   output logic             o_dv,
   output logic             o_busy,
   output logic             o_frame_err
`ifdef UART_RX_PARITY_EN
   ,
   output logic             o_parity_err
`endif
);

   localparam int TW = $clog2(DIVISOR);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [TW-1:0] START_MID = TW'(half_div(DIVISOR) - 1);
   localparam logic [TW-1:0] BIT_END   = TW'(DIVISOR - 1);
   localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);

   if (!divisor_ok(DIVISOR)) begin : g_bad_divisor
      $error("uart_rx: DIVISOR must be even and at least 4");
   end

   uart_rx_state_t   state;
   uart_rx_state_t   state_next;
   logic             rx_s;
   logic [TW-1:0]    timer;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] shreg;
   logic             at_mid;
   logic             shift_en;
   logic             dv_set;
   logic             ferr_set;

   uart_rx_sync #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (i_reset_n),
      .d     (i_rx),
      .q     (rx_s)
   );

   // State register.
   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) state <= IDLE;
      else            state <= state_next;
   end

   // Next-state decode and strobe requests; all decisions use the synchronized line.
   always_comb begin
      state_next = state;
      shift_en   = 1'b0;
      dv_set     = 1'b0;
      ferr_set   = 1'b0;
      at_mid     = (state == START) ? (timer == START_MID) : (timer == BIT_END);
      case (state)
         IDLE: begin
            // IDLE is only ever entered with the line high, so a low level here is a falling edge.
            if (!rx_s) state_next = START;
         end
         START: begin
            if (at_mid) state_next = rx_s ? IDLE : DATA;
         end
         DATA: begin
            if (at_mid) begin
               shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
               if (bit_cnt == LAST_BIT) state_next = PARITY;
`else
               if (bit_cnt == LAST_BIT) state_next = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (at_mid) state_next = STOP;
         end
`endif
         STOP: begin
            if (at_mid) begin
               if (rx_s) begin
                  dv_set     = 1'b1;
                  state_next = IDLE;
               end else begin
                  ferr_set   = 1'b1;
                  state_next = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            if (rx_s) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Bit timer: restarts on every state change and wraps after a full bit period.
   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n)                                             timer <= '0;
      else if (state == IDLE || state_next != state || timer == BIT_END) timer <= '0;
      else                                                        timer <= timer + 1'b1;
   end

   // Data bit counter, live only while collecting data bits.
   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n)         bit_cnt <= '0;
      else if (state != DATA) bit_cnt <= '0;
      else if (shift_en)      bit_cnt <= bit_cnt + 1'b1;
   end

   // Shift register collecting data bits in the configured order.
   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         shreg <= '0;
      end else if (shift_en) begin
         if (LITTLE_ENDIAN != 0) shreg <= {rx_s, shreg[WIDTH-1:1]};
         else                    shreg <= {shreg[WIDTH-2:0], rx_s};
      end
   end

   // Registered outputs: the word is published only for a frame with a good stop bit.
   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_data      <= '0;
         o_dv        <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         o_dv        <= dv_set;
         o_frame_err <= ferr_set;
         if (dv_set) o_data <= shreg;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_bad;

   // Even parity: the received parity bit must equal the XOR of the data bits; reported with the stop result.
   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         par_bad      <= 1'b0;
         o_parity_err <= 1'b0;
      end else begin
         if (state == PARITY && at_mid) par_bad <= rx_s ^ (^shreg);
         o_parity_err <= (state == STOP) && at_mid && par_bad;
      end
   end
`endif

   assign o_busy = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);

endmodule
`default_nettype wire
